// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and handshake FSM states for the
// sequential ALU and its multiplier.
package alu_pkg;

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_NOT  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MOV  = 8'h0D;
  localparam logic [7:0] OP_MUL  = 8'h0E;
  localparam logic [7:0] OP_LSH  = 8'h40;
  localparam logic [7:0] OP_ASH  = 8'h44;

  localparam int FLG_C = 0;
  localparam int FLG_L = 1;
  localparam int FLG_F = 2;
  localparam int FLG_Z = 3;
  localparam int FLG_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned radix-2 shift-add multiplier: start loads operands, then exactly
// WIDTH cycles later done pulses with the full 2*WIDTH product on product.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  logic               run;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc_nxt;

  always_comb begin
    acc_nxt = acc;
    if (mplier[0]) acc_nxt = acc + mcand;
  end

  // The final partial product is folded in combinationally so the product is
  // presented in the same cycle as done.
  assign done    = run && (cnt == CW'(WIDTH - 1));
  assign product = acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (run) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with valid/ready in and out channels, a persistent {N,Z,F,L,C}
// flag register and a multi-cycle multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags,
  output logic             busy
);

  state_t               state, state_nxt;
  logic                 accept;
  logic                 mul_start;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_prod;
  logic [WIDTH-1:0]     op_res;
  logic [4:0]           op_flg;
  logic                 upd_zn;
  logic [WIDTH:0]       sum;
  logic signed [WIDTH-1:0] sa, sb;

  assign sa = a;
  assign sb = b;

  // Positive amount shifts left; negative shifts right, saturating once the
  // magnitude reaches WIDTH.
  function automatic logic [WIDTH-1:0] shift_op(input logic [WIDTH-1:0] v,
                                                 input logic [SHW-1:0] amt,
                                                 input logic arith);
    logic [SHW:0]            mag;
    logic signed [WIDTH-1:0] sv;
    sv = v;
    if (!amt[SHW-1]) return v << amt[SHW-2:0];
    mag = -{amt[SHW-1], amt};
    if (mag >= (SHW+1)'(WIDTH)) begin
      if (arith) return {WIDTH{v[WIDTH-1]}};
      return '0;
    end
    if (arith) return sv >>> mag;
    return v >> mag;
  endfunction

  assign in_ready  = rst_n && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (opcode == OP_MUL);
  assign out_valid = (state == HOLD);
  assign busy      = (state == MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    op_res = '0;
    op_flg = flags;
    upd_zn = 1'b0;
    sum    = '0;
    case (opcode)
      OP_AND: begin op_res = a & b; upd_zn = 1'b1; end
      OP_OR:  begin op_res = a | b; upd_zn = 1'b1; end
      OP_XOR: begin op_res = a ^ b; upd_zn = 1'b1; end
      OP_NOT: begin op_res = ~a;    upd_zn = 1'b1; end
      OP_MOV: begin op_res = b;     upd_zn = 1'b1; end
      OP_ADD, OP_ADDC: begin
        sum = {1'b0, a} + {1'b0, b};
        if (opcode == OP_ADDC) sum = sum + {{WIDTH{1'b0}}, flags[FLG_C]};
        op_res        = sum[WIDTH-1:0];
        op_flg[FLG_C] = sum[WIDTH];
        op_flg[FLG_F] = (a[WIDTH-1] == b[WIDTH-1]) && (op_res[WIDTH-1] != a[WIDTH-1]);
        upd_zn        = 1'b1;
      end
      OP_ADDU: begin
        sum           = {1'b0, a} + {1'b0, b};
        op_res        = sum[WIDTH-1:0];
        op_flg[FLG_C] = sum[WIDTH];
      end
      OP_SUB: begin
        sum           = {1'b0, a} - {1'b0, b};
        op_res        = sum[WIDTH-1:0];
        op_flg[FLG_C] = sum[WIDTH];
        op_flg[FLG_F] = (a[WIDTH-1] != b[WIDTH-1]) && (op_res[WIDTH-1] != a[WIDTH-1]);
        upd_zn        = 1'b1;
      end
      OP_CMP: begin
        op_res        = a;
        op_flg[FLG_L] = (a < b);
        op_flg[FLG_N] = (sa < sb);
        op_flg[FLG_Z] = (a == b);
      end
      OP_LSH: begin
        op_res        = shift_op(a, b[SHW-1:0], 1'b0);
        op_flg[FLG_Z] = (op_res == '0);
      end
      OP_ASH: begin
        op_res        = shift_op(a, b[SHW-1:0], 1'b1);
        op_flg[FLG_Z] = (op_res == '0);
      end
      default: op_res = '0;
    endcase
    if (upd_zn) begin
      op_flg[FLG_Z] = (op_res == '0);
      op_flg[FLG_N] = op_res[WIDTH-1];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (opcode == OP_MUL) ? MUL : HOLD;
      MUL:  if (mul_done) state_nxt = HOLD;
      HOLD: begin
        if (accept)         state_nxt = (opcode == OP_MUL) ? MUL : HOLD;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Multiply only touches C; all other flags survive from the previous op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      flags  <= '0;
    end else if (accept && (opcode != OP_MUL)) begin
      result <= op_res;
      flags  <= op_flg;
    end else if ((state == MUL) && mul_done) begin
      result       <= mul_prod[WIDTH-1:0];
      flags[FLG_C] <= |mul_prod[2*WIDTH-1:WIDTH];
    end
  end

endmodule
